// File: rtl/tage_update_ctrl.sv
// tage_update_ctrl
//   Write-back sequencer for a TAGE branch predictor. It accepts one resolved
//   branch per handshake. In the following cycle it updates the provider's
//   saturating counter and useful bits. On a mispredict it allocates an entry
//   in a longer-history component. After every 2^AGE_PERIOD_WIDTH accepted
//   updates it sweeps every index so the tables can halve their useful bits.
//
//   Component 0 is the base bimodal table. Components 1..N_COMPONENTS-1 are tagged.
//
//   Handshake: a request transfers on a rising edge where upd_valid and
//   upd_ready are both 1. upd_ready is a function of state only: it is 1 in
//   IDLE and forced to 0 while rst is high. It never depends on upd_valid.
//   The upd_* fields are sampled only on the transfer edge.
//
//   Ports
//     clk, rst            clock, synchronous active-high reset
//     upd_valid/ready     request handshake
//     upd_taken           actual branch outcome
//     upd_predicted       provider (final) prediction
//     upd_alt_taken       alternate prediction
//     upd_provider_index  providing component (0 = base)
//     upd_ctr             per-component counters read at predict time
//     upd_useful          per-tagged-component useful bits
//     wr_ctr_en/wr_ctr    counter write enable and data, one field per component
//     wr_u_en/wr_u        useful write enable and data, tagged components
//     wr_alloc            one-hot allocate (tag write, weak ctr on wr_ctr, u=0)
//     age_valid/age_index sweep write: halve useful bits at age_index
//
//   Optional feature macro: TAGE_ALLOC_LFSR_EN. When it is defined, a 16-bit
//   LFSR picks the second-smallest free allocation candidate when its bit 0 is set.
//
//   FSM state is visible as the internal signal 'state' (IDLE/WRITE/SWEEP).
module tage_update_ctrl #(
    parameter int N_COMPONENTS     = 5,
    parameter int CTR_WIDTH        = 3,
    parameter int U_WIDTH          = 2,
    parameter int INDEX_WIDTH      = 10,
    parameter int AGE_PERIOD_WIDTH = 18,
    localparam int IW              = $clog2(N_COMPONENTS)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  upd_valid,
    output logic                                  upd_ready,
    input  logic                                  upd_taken,
    input  logic                                  upd_predicted,
    input  logic                                  upd_alt_taken,
    input  logic [IW-1:0]                         upd_provider_index,
    input  logic [N_COMPONENTS*CTR_WIDTH-1:0]     upd_ctr,
    input  logic [(N_COMPONENTS-1)*U_WIDTH-1:0]   upd_useful,
    output logic [N_COMPONENTS-1:0]               wr_ctr_en,
    output logic [N_COMPONENTS*CTR_WIDTH-1:0]     wr_ctr,
    output logic [N_COMPONENTS-2:0]               wr_u_en,
    output logic [(N_COMPONENTS-1)*U_WIDTH-1:0]   wr_u,
    output logic [N_COMPONENTS-2:0]               wr_alloc,
    output logic                                  age_valid,
    output logic [INDEX_WIDTH-1:0]                age_index
);

    localparam int NT = N_COMPONENTS - 1;
    localparam logic [CTR_WIDTH-1:0] WEAK_TAKEN     = CTR_WIDTH'(1) << (CTR_WIDTH - 1);
    localparam logic [CTR_WIDTH-1:0] WEAK_NOT_TAKEN = ~WEAK_TAKEN;

    typedef enum logic [1:0] {IDLE, WRITE, SWEEP} state_t;

    state_t                          state, state_nxt;
    logic                            req_taken, req_predicted, req_alt;
    logic [IW-1:0]                   req_prov;
    logic [N_COMPONENTS*CTR_WIDTH-1:0] req_ctr;
    logic [NT*U_WIDTH-1:0]           req_useful;
    logic [AGE_PERIOD_WIDTH-1:0]     age_cnt;
    logic                            sweep_pend;
    logic [INDEX_WIDTH-1:0]          age_idx;
    logic                            handshake;

`ifdef TAGE_ALLOC_LFSR_EN
    logic [15:0]                     lfsr;
`endif

    assign upd_ready = (state == IDLE) && !rst;
    assign handshake = upd_valid && upd_ready;
    assign age_valid = (state == SWEEP);
    assign age_index = age_idx;

    function automatic logic [CTR_WIDTH-1:0] ctr_step(input logic [CTR_WIDTH-1:0] c,
                                                      input logic up);
        if (up)
            return (&c) ? c : c + 1'b1;
        else
            return (c == '0) ? c : c - 1'b1;
    endfunction

    function automatic logic [U_WIDTH-1:0] u_step(input logic [U_WIDTH-1:0] u,
                                                  input logic up);
        if (up)
            return (&u) ? u : u + 1'b1;
        else
            return (u == '0) ? u : u - 1'b1;
    endfunction

    // ---------------------------------------------------------------
    // State, request capture, age counter and sweep index
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            age_cnt       <= '0;
            age_idx       <= '0;
            sweep_pend    <= 1'b0;
            req_taken     <= 1'b0;
            req_predicted <= 1'b0;
            req_alt       <= 1'b0;
            req_prov      <= '0;
            req_ctr       <= '0;
            req_useful    <= '0;
        end else begin
            state <= state_nxt;
            if (handshake) begin
                req_taken     <= upd_taken;
                req_predicted <= upd_predicted;
                req_alt       <= upd_alt_taken;
                req_prov      <= upd_provider_index;
                req_ctr       <= upd_ctr;
                req_useful    <= upd_useful;
                age_cnt       <= age_cnt + 1'b1;
                // The counter wraps to zero on this handshake exactly when it is all ones now.
                sweep_pend    <= &age_cnt;
            end
            // The sweep index wraps back to 0 on its last step, so it is ready for the next sweep.
            if (state == SWEEP)
                age_idx <= age_idx + 1'b1;
        end
    end

`ifdef TAGE_ALLOC_LFSR_EN
    always_ff @(posedge clk) begin
        if (rst)
            lfsr <= 16'hACE1;
        else if (handshake)
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
`endif

    // ---------------------------------------------------------------
    // Next state
    // ---------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (handshake) state_nxt = WRITE;
            WRITE:   state_nxt = sweep_pend ? SWEEP : IDLE;
            SWEEP:   if (&age_idx) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Write datapath, driven from the registered request in WRITE only
    // ---------------------------------------------------------------
    logic          mispredict;
    logic          first_found, second_found;
    logic [IW-1:0] first_k, second_k, alloc_k;

    always_comb begin
        mispredict   = (req_predicted != req_taken);
        first_found  = 1'b0;
        second_found = 1'b0;
        first_k      = '0;
        second_k     = '0;

        // Free candidates are components above the provider whose useful bits are zero.
        for (int k = 1; k < N_COMPONENTS; k++) begin
            if (IW'(k) > req_prov && req_useful[(k-1)*U_WIDTH +: U_WIDTH] == '0) begin
                if (!first_found) begin
                    first_found = 1'b1;
                    first_k     = IW'(k);
                end else if (!second_found) begin
                    second_found = 1'b1;
                    second_k     = IW'(k);
                end
            end
        end

`ifdef TAGE_ALLOC_LFSR_EN
        alloc_k = (second_found && lfsr[0]) ? second_k : first_k;
`else
        alloc_k = first_k;
`endif
    end

    always_comb begin
        wr_ctr_en = '0;
        wr_ctr    = '0;
        wr_u_en   = '0;
        wr_u      = '0;
        wr_alloc  = '0;

        if (state == WRITE) begin
            // Provider counter, saturating toward the actual outcome.
            for (int k = 0; k < N_COMPONENTS; k++) begin
                if (req_prov == IW'(k)) begin
                    wr_ctr_en[k] = 1'b1;
                    wr_ctr[k*CTR_WIDTH +: CTR_WIDTH] =
                        ctr_step(req_ctr[k*CTR_WIDTH +: CTR_WIDTH], req_taken);
                end
            end

            // Useful bits move only when the provider disagreed with the alternate.
            if (req_prov != '0 && req_predicted != req_alt) begin
                for (int k = 1; k < N_COMPONENTS; k++) begin
                    if (req_prov == IW'(k)) begin
                        wr_u_en[k-1] = 1'b1;
                        wr_u[(k-1)*U_WIDTH +: U_WIDTH] =
                            u_step(req_useful[(k-1)*U_WIDTH +: U_WIDTH], !mispredict);
                    end
                end
            end

            // On a mispredict, allocate above the provider, or age the blockers if none is free.
            // Both write components above the provider, so they cannot collide with the provider's useful write.
            if (mispredict && req_prov < IW'(NT)) begin
                for (int k = 1; k < N_COMPONENTS; k++) begin
                    if (first_found) begin
                        if (alloc_k == IW'(k)) begin
                            wr_alloc[k-1] = 1'b1;
                            wr_ctr_en[k]  = 1'b1;
                            wr_ctr[k*CTR_WIDTH +: CTR_WIDTH] =
                                req_taken ? WEAK_TAKEN : WEAK_NOT_TAKEN;
                        end
                    end else if (IW'(k) > req_prov) begin
                        wr_u_en[k-1] = 1'b1;
                        wr_u[(k-1)*U_WIDTH +: U_WIDTH] =
                            u_step(req_useful[(k-1)*U_WIDTH +: U_WIDTH], 1'b0);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tage_update_ctrl.sv
// tb_tage_update_ctrl
//   Directed, table-driven bench for tage_update_ctrl with N_COMPONENTS=5,
//   CTR_WIDTH=3, U_WIDTH=2, INDEX_WIDTH=2 and AGE_PERIOD_WIDTH=3.
//   Each vector record holds request fields and the hand-computed write-port image.
//   Hand-written sequences cover the aging sweep and a reset taken in the middle of a sweep.
module tb_tage_update_ctrl;

    localparam int NC  = 5;
    localparam int CW  = 3;
    localparam int UW  = 2;
    localparam int XW  = 2;
    localparam int APW = 3;
    localparam int IW  = 3;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    upd_valid = 1'b0;
    logic                    upd_ready;
    logic                    upd_taken = 1'b0;
    logic                    upd_predicted = 1'b0;
    logic                    upd_alt_taken = 1'b0;
    logic [IW-1:0]           upd_provider_index = '0;
    logic [NC*CW-1:0]        upd_ctr = '0;
    logic [(NC-1)*UW-1:0]    upd_useful = '0;
    logic [NC-1:0]           wr_ctr_en;
    logic [NC*CW-1:0]        wr_ctr;
    logic [NC-2:0]           wr_u_en;
    logic [(NC-1)*UW-1:0]    wr_u;
    logic [NC-2:0]           wr_alloc;
    logic                    age_valid;
    logic [XW-1:0]           age_index;

    tage_update_ctrl #(
        .N_COMPONENTS(NC), .CTR_WIDTH(CW), .U_WIDTH(UW),
        .INDEX_WIDTH(XW), .AGE_PERIOD_WIDTH(APW)
    ) dut (
        .clk(clk), .rst(rst),
        .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_taken(upd_taken), .upd_predicted(upd_predicted),
        .upd_alt_taken(upd_alt_taken), .upd_provider_index(upd_provider_index),
        .upd_ctr(upd_ctr), .upd_useful(upd_useful),
        .wr_ctr_en(wr_ctr_en), .wr_ctr(wr_ctr),
        .wr_u_en(wr_u_en), .wr_u(wr_u), .wr_alloc(wr_alloc),
        .age_valid(age_valid), .age_index(age_index)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- vectors ----------------
    typedef struct {
        logic                 taken;
        logic                 pred;
        logic                 alt;
        logic [IW-1:0]        prov;
        logic [NC*CW-1:0]     ctr;       // {c4,c3,c2,c1,c0}
        logic [(NC-1)*UW-1:0] useful;    // {u4,u3,u2,u1}
        logic [NC-1:0]        e_ctr_en;
        logic [NC*CW-1:0]     e_ctr;
        logic [NC-2:0]        e_u_en;
        logic [(NC-1)*UW-1:0] e_u;
        logic [NC-2:0]        e_alloc;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_total++;
        if (act === exp_v)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp_v);
    endtask

    function automatic logic [NC*CW-1:0] ctr_mask(input logic [NC-1:0] en);
        logic [NC*CW-1:0] m = '0;
        for (int k = 0; k < NC; k++) m[k*CW +: CW] = {CW{en[k]}};
        return m;
    endfunction

    function automatic logic [(NC-1)*UW-1:0] u_mask(input logic [NC-2:0] en);
        logic [(NC-1)*UW-1:0] m = '0;
        for (int k = 0; k < NC-1; k++) m[k*UW +: UW] = {UW{en[k]}};
        return m;
    endfunction

    // ---------------- driver ----------------
    // Starts and ends at a negedge. It returns while the DUT is in WRITE for this request.
    task automatic do_req(input vec_t v, input string tag);
        int w;
        @(negedge clk);
        w = 0;
        while (!upd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_ready_wait"}, 32'(upd_ready), 32'd1);
        upd_valid          = 1'b1;
        upd_taken          = v.taken;
        upd_predicted      = v.pred;
        upd_alt_taken      = v.alt;
        upd_provider_index = v.prov;
        upd_ctr            = v.ctr;
        upd_useful         = v.useful;
        @(negedge clk);
        upd_valid = 1'b0;
        chk({tag, "_ctr_en"}, 32'(wr_ctr_en), 32'(v.e_ctr_en));
        chk({tag, "_ctr"},    32'(wr_ctr & ctr_mask(wr_ctr_en)), 32'(v.e_ctr & ctr_mask(v.e_ctr_en)));
        chk({tag, "_u_en"},   32'(wr_u_en), 32'(v.e_u_en));
        chk({tag, "_u"},      32'(wr_u & u_mask(wr_u_en)), 32'(v.e_u & u_mask(v.e_u_en)));
        chk({tag, "_alloc"},  32'(wr_alloc), 32'(v.e_alloc));
        chk({tag, "_busy"},   32'(upd_ready), 32'd0);
    endtask

    // ---------------- test ----------------
    initial begin
        //           tk   pr   alt  prov  ctr {c4,c3,c2,c1,c0}                      useful {u4,u3,u2,u1}      e_ctr_en   e_ctr                                         e_u_en   e_u                         e_alloc
        vecs[0] = '{1'b1,1'b1,1'b1,3'd0,{3'd0,3'd0,3'd0,3'd0,3'b101},    {2'd0,2'd0,2'd0,2'd0}, 5'b00001, {3'd0,3'd0,3'd0,3'd0,3'b110},     4'b0000, {2'd0,2'd0,2'd0,2'd0}, 4'b0000};
        vecs[1] = '{1'b1,1'b1,1'b0,3'd2,{3'd0,3'd0,3'b111,3'd0,3'd0},    {2'd0,2'd0,2'd3,2'd0}, 5'b00100, {3'd0,3'd0,3'b111,3'd0,3'd0},     4'b0010, {2'd0,2'd0,2'd3,2'd0}, 4'b0000};
        vecs[2] = '{1'b0,1'b1,1'b1,3'd1,{3'd0,3'd0,3'd0,3'b100,3'd0},    {2'd0,2'd0,2'd1,2'd2}, 5'b01010, {3'd0,3'b011,3'd0,3'b011,3'd0},   4'b0000, {2'd0,2'd0,2'd0,2'd0}, 4'b0100};
        vecs[3] = '{1'b0,1'b1,1'b1,3'd2,{3'd0,3'd0,3'b000,3'd0,3'd0},    {2'd1,2'd2,2'd3,2'd0}, 5'b00100, {3'd0,3'd0,3'b000,3'd0,3'd0},     4'b1100, {2'd0,2'd1,2'd0,2'd0}, 4'b0000};
        vecs[4] = '{1'b1,1'b0,1'b1,3'd3,{3'd0,3'b011,3'd0,3'd0,3'd0},    {2'd0,2'd1,2'd0,2'd0}, 5'b11000, {3'b100,3'b100,3'd0,3'd0,3'd0},   4'b0100, {2'd0,2'd0,2'd0,2'd0}, 4'b1000};
        vecs[5] = '{1'b1,1'b0,1'b0,3'd4,{3'b010,3'd0,3'd0,3'd0,3'd0},    {2'd3,2'd3,2'd3,2'd3}, 5'b10000, {3'b011,3'd0,3'd0,3'd0,3'd0},     4'b0000, {2'd0,2'd0,2'd0,2'd0}, 4'b0000};
        vecs[6] = '{1'b0,1'b1,1'b0,3'd1,{3'd0,3'd0,3'd0,3'b000,3'd0},    {2'd1,2'd1,2'd0,2'd0}, 5'b00110, {3'd0,3'd0,3'b011,3'b000,3'd0},   4'b0001, {2'd0,2'd0,2'd0,2'd0}, 4'b0010};

        // ---- reset state ----
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready",  32'(upd_ready), 32'd0);
        chk("rst_outs",   32'({wr_ctr_en, wr_u_en, wr_alloc, age_valid}), 32'd0);
        chk("rst_ctr",    32'(wr_ctr), 32'd0);
        chk("rst_idx",    32'(age_index), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_release_ready", 32'(upd_ready), 32'd1);

        // ---- table vectors (7 updates, below the 8-update aging period) ----
        for (int i = 0; i < NV; i++)
            do_req(vecs[i], $sformatf("v%0d", i));
        @(negedge clk);
        chk("post_vec_ready", 32'(upd_ready), 32'd1);
        chk("post_vec_noage", 32'(age_valid), 32'd0);

        // ---- aging: reset the age counter, then 8 back-to-back updates ----
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++)
            do_req(vecs[i % NV], $sformatf("age%0d", i));
        // Hold valid through the sweep; it must be ignored.
        upd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("sweep%0d_valid", i), 32'(age_valid), 32'd1);
            chk($sformatf("sweep%0d_idx", i),   32'(age_index), 32'(i));
            chk($sformatf("sweep%0d_ready", i), 32'(upd_ready), 32'd0);
            chk($sformatf("sweep%0d_wr", i),    32'({wr_ctr_en, wr_u_en, wr_alloc}), 32'd0);
        end
        upd_valid = 1'b0;
        @(negedge clk);
        chk("sweep_done_ready", 32'(upd_ready), 32'd1);
        chk("sweep_done_age",   32'(age_valid), 32'd0);

        // ---- reset in the middle of a sweep ----
        for (int i = 0; i < 8; i++)
            do_req(vecs[0], $sformatf("mid%0d", i));
        @(negedge clk);
        chk("mid_idx0", 32'(age_index), 32'd0);
        @(negedge clk);
        chk("mid_idx1", 32'(age_index), 32'd1);
        chk("mid_valid1", 32'(age_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_age",   32'(age_valid), 32'd0);
        chk("mid_rst_ready", 32'(upd_ready), 32'd0);
        chk("mid_rst_idx",   32'(age_index), 32'd0);
        rst = 1'b0;
        #1;
        chk("mid_release_ready", 32'(upd_ready), 32'd1);
        for (int i = 0; i < 7; i++)
            do_req(vecs[i], $sformatf("re%0d", i));
        @(negedge clk);
        chk("re7_noage",  32'(age_valid), 32'd0);
        chk("re7_ready",  32'(upd_ready), 32'd1);
        do_req(vecs[0], "re8");
        @(negedge clk);
        chk("re8_age",    32'(age_valid), 32'd1);
        chk("re8_idx",    32'(age_index), 32'd0);
        repeat (4) @(negedge clk);
        chk("re8_end_ready", 32'(upd_ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
